// File: rtl/hdlc_stream_checker.sv
// Multi-channel HDLC receive-path checker: re-derives flag/abort events from the Rx
// streams, verifies the receiver strobes arrive at the programmed latencies, counts and captures errors.
module hdlc_stream_checker #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] Rx,
  input  logic [NUM_CH-1:0] Rx_FlagDetect,
  input  logic [NUM_CH-1:0] Rx_AbortDetect,
  input  logic [NUM_CH-1:0] Rx_ValidFrame,
  input  logic [NUM_CH-1:0] Rx_AbortSignal,
  input  logic [NUM_CH-1:0] Ch_En,
  input  logic              Clr,
  output logic              Err_Valid,
  output logic [3:0]        Err_Ch,
  output logic [1:0]        Err_Kind,
  output logic [CNT_W-1:0]  Err_Cnt,
  output logic              First_Valid,
  output logic [3:0]        First_Ch,
  output logic [1:0]        First_Kind
);
  localparam int ERR_W = 4 * NUM_CH;

  logic [ERR_W-1:0] errVec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gCh
      logic [7:0]           shReg;
      logic [3:0]           fillReg;
      logic [FLAG_LAT-1:0]  flagPipeReg;
      logic [ABORT_LAT-1:0] abortPipeReg;
      logic                 sigExpReg;
      logic [7:0]           window;
      logic                 armed;
      logic                 flagHit;
      logic                 abortHit;
      logic                 flagDue;
      logic                 abortDue;

      // The incoming bit is matched together with the 7 stored ones, so a hit enters
      // the pipeline on the same edge that samples the pattern's last bit.
      assign window   = {shReg[6:0], Rx[gi]};
      assign armed    = Ch_En[gi] && (fillReg >= 4'd7);
      assign flagHit  = armed && (window == 8'b0111_1110);
      assign abortHit = armed && (window == 8'b0111_1111);
      assign flagDue  = flagPipeReg[FLAG_LAT-1];
      assign abortDue = abortPipeReg[ABORT_LAT-1];

      always_ff @(posedge Clk) begin
        if (!Rst) begin
          shReg        <= '0;
          fillReg      <= '0;
          flagPipeReg  <= '0;
          abortPipeReg <= '0;
          sigExpReg    <= 1'b0;
        end else begin
          shReg <= window;
          if (!Ch_En[gi]) begin
            fillReg      <= '0;
            flagPipeReg  <= '0;
            abortPipeReg <= '0;
            sigExpReg    <= 1'b0;
          end else begin
            if (fillReg != 4'd8) fillReg <= fillReg + 4'd1;
            flagPipeReg  <= (flagPipeReg << 1) | FLAG_LAT'(flagHit);
            abortPipeReg <= (abortPipeReg << 1) | ABORT_LAT'(abortHit);
            sigExpReg    <= Rx_AbortDetect[gi] & Rx_ValidFrame[gi];
          end
        end
      end

      assign errVec[4*gi+0] = Ch_En[gi] & flagDue & ~Rx_FlagDetect[gi];
      assign errVec[4*gi+1] = Ch_En[gi] & abortDue & ~Rx_AbortDetect[gi];
      assign errVec[4*gi+2] = Ch_En[gi] & sigExpReg & ~Rx_AbortSignal[gi];
      assign errVec[4*gi+3] = Ch_En[gi] & ~flagDue & Rx_FlagDetect[gi];
    end
  endgenerate

  logic             anyErr;
  logic [5:0]       prioIdx;
  logic [6:0]       errPop;
  logic [CNT_W-1:0] cntBase;
  logic [CNT_W+7:0] cntSum;
  logic [CNT_W-1:0] cntNext;
  logic             firstHeld;

  // Scanning downward leaves the lowest set index, i.e. lowest channel then lowest kind.
  always_comb begin
    prioIdx = '0;
    errPop  = '0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (errVec[i]) prioIdx = 6'(i);
      errPop = errPop + 7'(errVec[i]);
    end
  end

  assign anyErr    = |errVec;
  assign cntBase   = Clr ? '0 : Err_Cnt;
  assign cntSum    = (CNT_W+8)'(cntBase) + (CNT_W+8)'(errPop);
  assign cntNext   = (cntSum > (CNT_W+8)'({CNT_W{1'b1}})) ? '1 : cntSum[CNT_W-1:0];
  assign firstHeld = First_Valid & ~Clr;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Err_Valid   <= 1'b0;
      Err_Ch      <= '0;
      Err_Kind    <= '0;
      Err_Cnt     <= '0;
      First_Valid <= 1'b0;
      First_Ch    <= '0;
      First_Kind  <= '0;
    end else begin
      Err_Valid <= anyErr;
      Err_Cnt   <= cntNext;
      if (anyErr) begin
        Err_Ch   <= prioIdx[5:2];
        Err_Kind <= prioIdx[1:0];
      end
      // Clr empties the capture first, so an error in the Clr cycle still lands in it.
      if (!firstHeld && anyErr) begin
        First_Valid <= 1'b1;
        First_Ch    <= prioIdx[5:2];
        First_Kind  <= prioIdx[1:0];
      end else if (Clr) begin
        First_Valid <= 1'b0;
        First_Ch    <= '0;
        First_Kind  <= '0;
      end
    end
  end
endmodule
